// File: rtl/ripple_count_capture_if.sv
// Snapshot request/handshake bundle for ripple_count_capture.
// Carries the overrun flag when RIPPLE_CAPTURE_OVERRUN_EN is defined.
interface ripple_count_capture_if #(
   parameter int WIDTH     = 4,
   parameter int EXT_WIDTH = 4
);
   logic                       sample_req;
   logic                       snap_valid;
   logic                       snap_ready;
   logic [WIDTH+EXT_WIDTH-1:0] snap_data;
   logic                       wrap_pulse;
   logic                       busy;
`ifdef RIPPLE_CAPTURE_OVERRUN_EN
   logic                       overrun;
`endif

   // Consumer side
   modport master (
      output sample_req,
      output snap_ready,
      input  snap_valid,
      input  snap_data,
      input  wrap_pulse,
`ifdef RIPPLE_CAPTURE_OVERRUN_EN
      input  overrun,
`endif
      input  busy
   );

   // Capture block side
   modport slave (
      input  sample_req,
      input  snap_ready,
      output snap_valid,
      output snap_data,
      output wrap_pulse,
`ifdef RIPPLE_CAPTURE_OVERRUN_EN
      output overrun,
`endif
      output busy
   );
endinterface

// File: rtl/ripple_count_capture.sv
// Synchronizes and de-glitches a ripple counter, extends it with wrap bits and
// serves snapshots over valid/ready. Optional sticky overrun flag: RIPPLE_CAPTURE_OVERRUN_EN.
module ripple_count_capture #(
   parameter int WIDTH         = 4,
   parameter int EXT_WIDTH     = 4,
   parameter int STABLE_CYCLES = 2
) (
   input  logic                   clock,
   input  logic                   clear,
   input  logic [WIDTH-1:0]       cnt_in,
   ripple_count_capture_if.slave  snap
);

   localparam int SC_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [SC_W-1:0] SC_MAX = SC_W'(STABLE_CYCLES);
   localparam logic [SC_W-1:0] SC_PRE = SC_W'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SETTLE, VALID} state_t;

   function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] v);
      return (v == SC_MAX) ? v : v + SC_W'(1);
   endfunction

   logic [WIDTH-1:0]           s1_p0;
   logic [WIDTH-1:0]           s2_p1;
   logic [WIDTH-1:0]           s2_prev_p2;
   logic [SC_W-1:0]            stable_cnt;
   logic [WIDTH-1:0]           settled_value;
   logic [EXT_WIDTH-1:0]       ext_count;
   logic                       wrap_pulse_r;
   state_t                     state;
   logic                       busy_r;
   logic                       snap_valid_r;
   logic [WIDTH+EXT_WIDTH-1:0] snap_data_r;

   logic                       same;
   logic                       accept;
   logic                       is_wrap;
   logic [WIDTH-1:0]           settled_nxt;
   logic [EXT_WIDTH-1:0]       ext_nxt;

   // An accept fires on the edge where the filter reaches saturation with a new value
   assign same        = (s2_p1 == s2_prev_p2);
   assign accept      = same && (stable_cnt == SC_PRE) && (s2_p1 != settled_value);
   assign is_wrap     = accept && (s2_p1 < settled_value);
   assign settled_nxt = accept  ? s2_p1 : settled_value;
   assign ext_nxt     = is_wrap ? ext_count + EXT_WIDTH'(1) : ext_count;

   // Stage p0..p2: two-flop synchronizer plus previous-sample register
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         s1_p0      <= '0;
         s2_p1      <= '0;
         s2_prev_p2 <= '0;
      end else begin
         s1_p0      <= cnt_in;
         s2_p1      <= s1_p0;
         s2_prev_p2 <= s2_p1;
      end
   end

   // Stability filter, accept and wrap extension
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         stable_cnt    <= '0;
         settled_value <= '0;
         ext_count     <= '0;
         wrap_pulse_r  <= 1'b0;
      end else begin
         stable_cnt    <= same ? sat_inc(stable_cnt) : '0;
         settled_value <= settled_nxt;
         ext_count     <= ext_nxt;
         wrap_pulse_r  <= is_wrap;
      end
   end

   // Snapshot FSM; loads next-state values so a same-edge accept is captured
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state        <= IDLE;
         busy_r       <= 1'b0;
         snap_valid_r <= 1'b0;
         snap_data_r  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (snap.sample_req) begin
                  state  <= SETTLE;
                  busy_r <= 1'b1;
               end
            end
            SETTLE: begin
               if ((stable_cnt == SC_MAX) || accept) begin
                  snap_data_r  <= {ext_nxt, settled_nxt};
                  snap_valid_r <= 1'b1;
                  state        <= VALID;
               end
            end
            VALID: begin
               if (snap.snap_ready) begin
                  snap_valid_r <= 1'b0;
                  busy_r       <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: begin
               state        <= IDLE;
               busy_r       <= 1'b0;
               snap_valid_r <= 1'b0;
            end
         endcase
      end
   end

`ifdef RIPPLE_CAPTURE_OVERRUN_EN
   logic overrun_r;

   // A dropped request in the completion cycle keeps the flag set
   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         overrun_r <= 1'b0;
      end else if (snap.sample_req && busy_r) begin
         overrun_r <= 1'b1;
      end else if (snap_valid_r && snap.snap_ready) begin
         overrun_r <= 1'b0;
      end
   end

   assign snap.overrun = overrun_r;
`endif

   assign snap.snap_valid = snap_valid_r;
   assign snap.snap_data  = snap_data_r;
   assign snap.wrap_pulse = wrap_pulse_r;
   assign snap.busy       = busy_r;

endmodule

// File: tb/tb_ripple_count_capture.sv
// Directed bench for ripple_count_capture with immediate-assertion checks.
// Overrun checks are included when RIPPLE_CAPTURE_OVERRUN_EN is defined.
module tb_ripple_count_capture;

  logic       clock;
  logic       clear;
  logic [3:0] cnt_in;
  int         errors;
  int         checks;

  ripple_count_capture_if #(.WIDTH(4), .EXT_WIDTH(4)) bus ();

  ripple_count_capture #(.WIDTH(4), .EXT_WIDTH(4), .STABLE_CYCLES(2)) dut (
    .clock  (clock),
    .clear  (clear),
    .cnt_in (cnt_in),
    .snap   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_snap(output logic [7:0] d, output logic ok);
    bus.sample_req = 1'b1;
    tick(1);
    bus.sample_req = 1'b0;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (bus.snap_valid) ok = 1'b1;
      else tick(1);
    end
    checks++;
    if (!ok) begin
      errors++;
      $error("FAIL snap_wait: snap_valid did not rise within 20 cycles");
    end
    d = bus.snap_data;
  endtask

  logic [7:0] d;
  logic       ok;
  logic       saw6;
  logic       sawwrap;

  initial begin
    errors = 0;
    checks = 0;
    clear = 1'b0;
    cnt_in = 4'h5;
    bus.sample_req = 1'b0;
    bus.snap_ready = 1'b0;

    // Reset state
    tick(3);
    check("rst_valid", bus.snap_valid, 1'b0);
    check("rst_data", bus.snap_data, 8'h00);
    check("rst_wrap", bus.wrap_pulse, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_settled", dut.settled_value, 4'h0);
`ifdef RIPPLE_CAPTURE_OVERRUN_EN
    check("rst_overrun", bus.overrun, 1'b0);
`endif

    // Release: 5 accepted on edge 5
    clear = 1'b1;
    tick(4);
    check("rel_edge4", dut.settled_value, 4'h0);
    tick(1);
    check("rel_edge5", dut.settled_value, 4'h5);
    check("rel_nowrap", bus.wrap_pulse, 1'b0);
    check("rel_ext", dut.ext_count, 4'h0);

    // Fresh start at 3, then step 3 -> 4
    clear = 1'b0;
    cnt_in = 4'h3;
    #2;
    clear = 1'b1;
    tick(8);
    check("step_base", dut.settled_value, 4'h3);
    cnt_in = 4'h4;
    tick(4);
    check("step_edge4", dut.settled_value, 4'h3);
    tick(1);
    check("step_edge5", dut.settled_value, 4'h4);

    // Wrap 15 -> 0
    cnt_in = 4'hF;
    tick(8);
    check("wrap_pre", dut.settled_value, 4'hF);
    check("wrap_pre_ext", dut.ext_count, 4'h0);
    cnt_in = 4'h0;
    tick(5);
    check("wrap_settled", dut.settled_value, 4'h0);
    check("wrap_ext", dut.ext_count, 4'h1);
    check("wrap_pulse_hi", bus.wrap_pulse, 1'b1);
    tick(1);
    check("wrap_pulse_lo", bus.wrap_pulse, 1'b0);
    do_snap(d, ok);
    check("wrap_snap_to", ok, 1'b1);
    check("wrap_snap", d, 8'h10);
    bus.snap_ready = 1'b1;
    tick(1);
    bus.snap_ready = 1'b0;
    check("wrap_xfer_valid", bus.snap_valid, 1'b0);

    // Glitch: 7 -> 6 for one clock -> 8
    cnt_in = 4'h7;
    tick(8);
    cnt_in = 4'h6;
    tick(1);
    cnt_in = 4'h8;
    saw6 = 1'b0;
    sawwrap = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (dut.settled_value == 4'h6) saw6 = 1'b1;
      if (bus.wrap_pulse) sawwrap = 1'b1;
    end
    check("glitch_no6", saw6, 1'b0);
    check("glitch_nowrap", sawwrap, 1'b0);
    check("glitch_final", dut.settled_value, 4'h8);

    // Backpressure with a dropped second request
    do_snap(d, ok);
    check("bp_snap_to", ok, 1'b1);
    check("bp_snap", d, 8'h18);
    for (int i = 0; i < 10; i++) begin
      cnt_in = 4'(9 + (i % 3));
      bus.sample_req = (i == 3);
      tick(1);
      check("bp_hold_valid", bus.snap_valid, 1'b1);
      check("bp_hold_data", bus.snap_data, 8'h18);
    end
    bus.sample_req = 1'b0;
`ifdef RIPPLE_CAPTURE_OVERRUN_EN
    check("bp_overrun_set", bus.overrun, 1'b1);
`endif
    bus.snap_ready = 1'b1;
    tick(1);
    bus.snap_ready = 1'b0;
    check("bp_xfer_valid", bus.snap_valid, 1'b0);
    check("bp_xfer_busy", bus.busy, 1'b0);
`ifdef RIPPLE_CAPTURE_OVERRUN_EN
    check("bp_overrun_clr", bus.overrun, 1'b0);
`endif
    tick(5);
    check("bp_no_second", bus.snap_valid, 1'b0);
    check("bp_idle_busy", bus.busy, 1'b0);

    // Reset while VALID
    tick(3);
    check("mid_pre_settled", dut.settled_value, 4'h9);
    do_snap(d, ok);
    check("mid_snap_to", ok, 1'b1);
    check("mid_snap", d, 8'h19);
    clear = 1'b0;
    #1;
    check("mid_async_valid", bus.snap_valid, 1'b0);
    check("mid_async_ext", dut.ext_count, 4'h0);
    check("mid_async_busy", bus.busy, 1'b0);
    @(posedge clock);
    #1;
    clear = 1'b1;
    tick(8);
    do_snap(d, ok);
    check("fresh_snap_to", ok, 1'b1);
    check("fresh_snap", d, 8'h09);
    bus.snap_ready = 1'b1;
    tick(1);
    bus.snap_ready = 1'b0;
    check("fresh_xfer_valid", bus.snap_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
